// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg
// Parametrised N-channel, W-bit registered multiplexer with per-channel
// valid/ready handshakes. Selection is either a fixed channel (mode = 0,
// channel = sel) or round-robin (mode = 1) starting after the last
// channel served. One output register stage; full throughput.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst_n     - synchronous active-low reset
//   mode      - 0 = fixed select, 1 = round-robin
//   sel       - channel used in fixed-select mode
//   in_data   - packed inputs, channel i = in_data[i*W +: W]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready (transfer on valid & ready)
//   out_data  - registered selected word
//   out_ch    - index of the channel that produced out_data
//   out_valid - out_data/out_ch valid
//   out_ready - consumer accepts on out_valid & out_ready
//   out_par   - even parity of out_data (only with MUXN_PARITY_EN)
//
// Configuration: define MUXN_PARITY_EN to add the out_par output.

module muxn_rr_reg #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
`ifdef MUXN_PARITY_EN
  output logic          out_par,
`endif
  input  logic          out_ready
);

  logic          ld;
  logic [N-1:0]  grant;
  logic          grant_any;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic [SW-1:0] last;

  assign ld = !out_valid || out_ready;

  // Nothing is accepted while reset is asserted, so a producer's word can
  // never be consumed by a transfer that the reset then throws away.
  assign in_ready = (ld && rst_n) ? grant : '0;

  // Round-robin scans last+1, last+2, ... wrapping and ending at last
  // itself; the first valid channel found wins. Fixed mode grants sel
  // only if it names an existing channel that is valid.
  always_comb begin
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i]   = 1'b1;
          grant_any  = 1'b1;
          grant_idx  = SW'(i);
          grant_data = in_data[i*W +: W];
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!grant_any && i == (int'(last) + k) % N && in_valid[i]) begin
            grant[i]   = 1'b1;
            grant_any  = 1'b1;
            grant_idx  = SW'(i);
            grant_data = in_data[i*W +: W];
          end
        end
      end
    end
  end

  // Output stage: loads whenever empty or being popped, so a pop and a new
  // load in the same cycle replace the word without a bubble. With no
  // grant the stage empties but keeps the last data/channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SW'(N - 1);
`ifdef MUXN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (ld) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
`ifdef MUXN_PARITY_EN
        out_par   <= ^grant_data;
`endif
        if (mode) begin
          last <= grant_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
